// File: rtl/axi_pkg.sv
// Shared AXI write/read-side types: burst encodings, response codes and controller states.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic [11:0] beat_bytes(input logic [2:0] size);
    return 12'd1 << size;
  endfunction

  // WRAP bursts are only legal at 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational beat-address stepper for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [3:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic [ADDR_W-1:0] o_wrap_boundary
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_incr;

  always_comb begin
    w_bytes         = ADDR_W'(beat_bytes(i_size));
    // total burst bytes minus one; a valid mask only for legal WRAP lengths
    w_mask          = (w_bytes * ADDR_W'({1'b0, i_len} + 5'd1)) - ADDR_W'(1);
    w_incr          = i_addr + w_bytes;
    o_next_addr     = i_addr;
    o_wrap_boundary = '0;
    case (i_burst)
      INCR: o_next_addr = w_incr;
      WRAP: begin
        o_wrap_boundary = i_addr & ~w_mask;
        o_next_addr     = o_wrap_boundary | (w_incr & w_mask);
      end
      default: o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI3 write-side slave: one burst at a time, per-beat memory write port, one B response per burst.
//   state | meaning
//   IDLE  | awready high, waiting for a burst request
//   DATA  | wready high, one memory beat per W handshake until len+1 beats
//   RESP  | bvalid high, bid/bresp held until bready
module axi_wr_slave_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 512
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ID_W-1:0]   i_awid,
  input  logic [3:0]        i_awlen,
  input  logic [2:0]        i_awsize,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic [1:0]        i_awburst,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [ID_W-1:0]   i_wid,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wlast,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic [ID_W-1:0]   o_bid,
  output logic [1:0]        o_bresp,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  output logic [ADDR_W-1:0] o_addr_wrapwr
);

  wr_state_e         r_state;
  wr_state_e         w_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [3:0]        r_len;
  logic [3:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic              r_burst_err;
  logic              r_err;

  logic              w_aw_hs;
  logic              w_beat;
  logic              w_last;
  logic              w_aw_err;
  logic              w_beat_err;
  logic [ADDR_W:0]   w_beat_end;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_wrap_bound;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr          (r_addr),
    .i_size          (r_size),
    .i_len           (r_len),
    .i_burst         (r_burst),
    .o_next_addr     (w_next_addr),
    .o_wrap_boundary (w_wrap_bound)
  );

  assign w_aw_hs    = i_awvalid && o_awready;
  assign w_beat     = i_wvalid && o_wready;
  assign w_last     = (r_cnt == r_len);
  assign w_aw_err   = (i_awsize > 3'd2) || (i_awburst == 2'b11) ||
                      ((i_awburst == WRAP) && !wrap_len_ok(i_awlen));
  // one extra bit so a beat ending exactly at the top of the address space cannot wrap to a small value
  assign w_beat_end = {1'b0, r_addr} + (ADDR_W+1)'(beat_bytes(r_size));
  assign w_beat_err = (w_beat_end > (ADDR_W+1)'(MEM_BYTES)) || (i_wid != r_id);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        o_awready = !i_reset;
        if (i_awvalid) w_state_nxt = DATA;
      end
      DATA: begin
        o_wready = 1'b1;
        if (i_wvalid && w_last) w_state_nxt = RESP;
      end
      RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_id        <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_addr      <= '0;
      r_burst_err <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_aw_hs) begin
      r_id        <= i_awid;
      r_len       <= i_awlen;
      r_cnt       <= '0;
      r_size      <= i_awsize;
      r_burst     <= i_awburst;
      r_addr      <= i_awaddr;
      r_burst_err <= w_aw_err;
      r_err       <= w_aw_err;
    end else if (w_beat) begin
      r_cnt  <= r_cnt + 4'd1;
      r_addr <= w_next_addr;
      // the burst always ends on the beat count; a misplaced wlast only flags the response
      if (w_beat_err || (i_wlast != w_last)) r_err <= 1'b1;
    end
  end

  assign o_bid         = r_id;
  assign o_bresp       = ((r_state == RESP) && r_err) ? SLVERR : OKAY;
  assign o_mem_we      = w_beat && !r_burst_err && !w_beat_err;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = i_wdata;
  assign o_mem_wstrb   = i_wstrb;
  assign o_addr_wrapwr = (r_state != IDLE) ? w_wrap_bound : '0;

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Self-checking bench: directed and random bursts against an arithmetic reference of the beat sequence.
module tb_axi_wr_slave_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_awvalid;
  logic        o_awready;
  logic [3:0]  i_awid;
  logic [3:0]  i_awlen;
  logic [2:0]  i_awsize;
  logic [31:0] i_awaddr;
  logic [1:0]  i_awburst;
  logic        i_wvalid;
  logic        o_wready;
  logic [3:0]  i_wid;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        i_wlast;
  logic        o_bvalid;
  logic        i_bready;
  logic [3:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_addr_wrapwr;

  int n_checks = 0;
  int n_errors = 0;

  axi_wr_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_BYTES(512)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_awvalid     (i_awvalid),
    .o_awready     (o_awready),
    .i_awid        (i_awid),
    .i_awlen       (i_awlen),
    .i_awsize      (i_awsize),
    .i_awaddr      (i_awaddr),
    .i_awburst     (i_awburst),
    .i_wvalid      (i_wvalid),
    .o_wready      (o_wready),
    .i_wid         (i_wid),
    .i_wdata       (i_wdata),
    .i_wstrb       (i_wstrb),
    .i_wlast       (i_wlast),
    .o_bvalid      (o_bvalid),
    .i_bready      (i_bready),
    .o_bid         (o_bid),
    .o_bresp       (o_bresp),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_wstrb   (o_mem_wstrb),
    .o_addr_wrapwr (o_addr_wrapwr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address of beat i, from the burst rules expressed with plain modulo arithmetic.
  function automatic int unsigned model_addr(int unsigned start, int len, int size, int burst, int i);
    int unsigned bytes, total, base;
    bytes = 32'd1 << size;
    total = bytes * (len + 1);
    case (burst)
      1: return start + i * bytes;
      2: begin
        base = start - (start % total);
        return base + ((start - base + i * bytes) % total);
      end
      default: return start;
    endcase
  endfunction

  task automatic run_burst(input int id, input int unsigned addr, input int len, input int size,
                           input int burst, input int bad_wid, input int bad_wlast, input int b_dly);
    int unsigned a, bytes, total, wbase;
    logic [31:0] wd;
    logic [3:0]  ws;
    bit berr, err, we;
    int t;
    bytes = 32'd1 << size;
    total = bytes * (len + 1);
    wbase = (burst == 2) ? addr - (addr % total) : 0;
    berr  = (size > 2) || (burst == 3) ||
            ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    err   = berr || (bad_wlast >= 0 && bad_wlast <= len);

    @(posedge i_clk); #1;
    i_awvalid = 1'b1; i_awid = 4'(id); i_awaddr = addr;
    i_awlen = 4'(len); i_awsize = 3'(size); i_awburst = 2'(burst);
    t = 0;
    @(negedge i_clk);
    while (!o_awready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    check("awready", 32'(o_awready), 32'd1);
    @(posedge i_clk); #1;
    i_awvalid = 1'b0;
    @(negedge i_clk);
    check("wready_lat", 32'(o_wready), 32'd1);
    check("awready_busy", 32'(o_awready), 32'd0);

    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk); #1;
        i_wvalid = 1'b0;
        @(negedge i_clk);
        check("we_gap", 32'(o_mem_we), 32'd0);
      end
      @(posedge i_clk); #1;
      wd = $urandom;
      ws = 4'($urandom);
      i_wvalid = 1'b1; i_wdata = wd; i_wstrb = ws;
      i_wid   = (i == bad_wid) ? 4'(id) ^ 4'd1 : 4'(id);
      i_wlast = (i == len) ^ (i == bad_wlast);
      a  = model_addr(addr, len, size, burst, i);
      we = !berr && (a + bytes <= 512) && (i != bad_wid);
      if (!we) err = 1'b1;
      @(negedge i_clk);
      check("wready", 32'(o_wready), 32'd1);
      check("mem_we", 32'(o_mem_we), 32'(we));
      if (!berr) begin
        check("mem_addr", o_mem_addr, a);
        check("wrap_bound", o_addr_wrapwr, wbase);
      end
      if (we) begin
        check("mem_wdata", o_mem_wdata, wd);
        check("mem_wstrb", 32'(o_mem_wstrb), 32'(ws));
      end
    end

    @(posedge i_clk); #1;
    i_wvalid = 1'b0; i_wlast = 1'b0;
    @(negedge i_clk);
    check("bvalid_lat", 32'(o_bvalid), 32'd1);
    check("wready_resp", 32'(o_wready), 32'd0);
    check("bid", 32'(o_bid), 32'(id[3:0]));
    check("bresp", 32'(o_bresp), err ? 32'd2 : 32'd0);
    repeat (b_dly) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("bvalid_hold", 32'(o_bvalid), 32'd1);
      check("bid_hold", 32'(o_bid), 32'(id[3:0]));
      check("bresp_hold", 32'(o_bresp), err ? 32'd2 : 32'd0);
      check("awready_resp", 32'(o_awready), 32'd0);
    end
    @(posedge i_clk); #1;
    i_bready = 1'b1;
    @(negedge i_clk);
    check("bvalid_pre_hs", 32'(o_bvalid), 32'd1);
    @(posedge i_clk); #1;
    i_bready = 1'b0;
    @(negedge i_clk);
    check("bvalid_clr", 32'(o_bvalid), 32'd0);
    check("awready_lat", 32'(o_awready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(o_awready), 32'd0);
    check({tag, "_wready"}, 32'(o_wready), 32'd0);
    check({tag, "_bvalid"}, 32'(o_bvalid), 32'd0);
    check({tag, "_bid"}, 32'(o_bid), 32'd0);
    check({tag, "_bresp"}, 32'(o_bresp), 32'd0);
    check({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
    check({tag, "_wrapwr"}, o_addr_wrapwr, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int size, burst, len, bad_wid, bad_wlast;
    int unsigned addr, bytes;
    i_reset = 1'b1; i_awvalid = 1'b0; i_awid = '0; i_awlen = '0; i_awsize = '0;
    i_awaddr = '0; i_awburst = '0; i_wvalid = 1'b0; i_wid = '0; i_wdata = '0;
    i_wstrb = '0; i_wlast = 1'b0; i_bready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("rst");
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check("awready_idle", 32'(o_awready), 32'd1);

    run_burst(3, 32'h10, 3, 2, 1, -1, -1, 1);
    run_burst(7, 32'h38, 3, 2, 2, -1, -1, 0);
    run_burst(2, 32'h20, 2, 2, 0, -1, -1, 0);
    run_burst(1, 32'h40, 1, 3, 1, -1, -1, 0);
    run_burst(4, 32'h40, 2, 2, 2, -1, -1, 0);
    run_burst(9, 32'h1FC, 1, 2, 1, -1, -1, 0);
    run_burst(6, 32'h80, 3, 2, 1, -1, -1, 5);
    run_burst(8, 32'h100, 3, 2, 1, 2, -1, 0);
    run_burst(10, 32'h100, 3, 1, 1, -1, 1, 0);
    run_burst(12, 32'h104, 2, 2, 1, -1, 2, 0);
    run_burst(11, 32'h0, 1, 2, 3, -1, -1, 0);

    // reset in the middle of a burst: aborted burst must give no response
    @(posedge i_clk); #1;
    i_awvalid = 1'b1; i_awid = 4'd5; i_awaddr = 32'h40; i_awlen = 4'd3;
    i_awsize = 3'd2; i_awburst = 2'd2;
    @(posedge i_clk); #1;
    i_awvalid = 1'b0; i_wvalid = 1'b1; i_wid = 4'd5; i_wlast = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_reset_outputs("midrst");
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_wvalid = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check("no_resp_after_rst", 32'(o_bvalid), 32'd0);
    end
    check("awready_after_rst", 32'(o_awready), 32'd1);

    for (int n = 0; n < 40; n++) begin
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      burst = ($urandom_range(0, 14) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2 && $urandom_range(0, 5) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom_range(0, 15));
      end
      bytes = 32'd1 << size;
      if ($urandom_range(0, 4) == 0) addr = 512 - bytes * $urandom_range(1, 3);
      else addr = $urandom_range(0, 511) & ~(bytes - 1);
      bad_wid   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      bad_wlast = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(int'($urandom_range(0, 15)), addr, len, size, burst, bad_wid, bad_wlast,
                int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
